// File: rtl/mv_stream_loader.sv
// mv_stream_loader: stream front end for the 4x4 systolic matrix-vector engine.
// It loads 16 matrix elements and 4 vector elements into the engine buses,
// holds eng_en high for a fixed window, captures the packed result and then
// streams the four result elements back out.
//
// state   | meaning
// --------+--------------------------------------------------------------
// LOAD    | accepting elements M1[0..3] .. M4[0..3], V[0..3]; checks framing
// RUN     | eng_en high, buses frozen, run counter 0..RUN_CYCLES-1
// CAPTURE | eng_en low, engine result latched into the capture register
// SEND    | result elements 0..3 streamed out with valid/ready
module mv_stream_loader #(
    parameter int DIMENSION  = 4,
    parameter int WIDTH      = 8,
    parameter int RUN_CYCLES = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    output logic                       frame_err,
    output logic                       busy,
    output logic                       eng_en,
    output logic [DIMENSION*WIDTH-1:0] eng_M1,
    output logic [DIMENSION*WIDTH-1:0] eng_M2,
    output logic [DIMENSION*WIDTH-1:0] eng_M3,
    output logic [DIMENSION*WIDTH-1:0] eng_M4,
    output logic [DIMENSION*WIDTH-1:0] eng_V,
    input  logic [DIMENSION*WIDTH-1:0] eng_MV
);

    localparam int BUS_W = DIMENSION * WIDTH;
    localparam int ELEMS = DIMENSION * (DIMENSION + 1);
    localparam int CNT_W = $clog2(ELEMS);
    localparam int RUN_W = $clog2(RUN_CYCLES);
    localparam int IDX_W = $clog2(DIMENSION);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ELEMS - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIMENSION - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BUS_W-1:0]   m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, m4_q, m4_d;
    logic [BUS_W-1:0]   v_q, v_d, cap_q, cap_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;
    logic               eng_en_q, eng_en_d;

    // Element counter split: with DIMENSION fixed at 4 the upper bits select
    // the bus (M1..M4, V) and the low two bits select the slice within it.
    logic [2:0]         elem_bus;
    logic [IDX_W-1:0]   elem_col;
    logic               elem_last;
    logic [IDX_W-1:0]   idx_inc;

    assign elem_bus  = cnt_q[CNT_W-1:IDX_W];
    assign elem_col  = cnt_q[IDX_W-1:0];
    assign elem_last = (cnt_q == CNT_LAST);
    assign idx_inc   = idx_q + 1'b1;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_cnt_d   = run_cnt_q;
        idx_d       = idx_q;
        m1_d        = m1_q;
        m2_d        = m2_q;
        m3_d        = m3_q;
        m4_d        = m4_q;
        v_d         = v_q;
        cap_d       = cap_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;
        busy_d      = busy_q;
        eng_en_d    = eng_en_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    // The element is written even when the framing is bad;
                    // a later good job overwrites every slice anyway.
                    case (elem_bus)
                        3'd0:    m1_d[elem_col*WIDTH +: WIDTH] = in_data;
                        3'd1:    m2_d[elem_col*WIDTH +: WIDTH] = in_data;
                        3'd2:    m3_d[elem_col*WIDTH +: WIDTH] = in_data;
                        3'd3:    m4_d[elem_col*WIDTH +: WIDTH] = in_data;
                        3'd4:    v_d[elem_col*WIDTH +: WIDTH]  = in_data;
                        default: ;
                    endcase
                    if (in_last != elem_last) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                    end else if (elem_last) begin
                        cnt_d      = '0;
                        state_d    = S_RUN;
                        in_ready_d = 1'b0;
                        eng_en_d   = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (run_cnt_q == RUN_LAST) begin
                    run_cnt_d = '0;
                    state_d   = S_CAPTURE;
                    eng_en_d  = 1'b0;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                // Element 0 comes straight from eng_MV because the capture
                // register only updates on this same edge.
                cap_d       = eng_MV;
                state_d     = S_SEND;
                idx_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = eng_MV[WIDTH-1:0];
                out_last_d  = 1'b0;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = S_LOAD;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        idx_d      = idx_inc;
                        out_data_d = cap_q[idx_inc*WIDTH +: WIDTH];
                        out_last_d = (idx_inc == IDX_LAST);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and registered outputs; synchronous active-low reset aborts any job.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            run_cnt_q   <= '0;
            idx_q       <= '0;
            m1_q        <= '0;
            m2_q        <= '0;
            m3_q        <= '0;
            m4_q        <= '0;
            v_q         <= '0;
            cap_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            eng_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_cnt_q   <= run_cnt_d;
            idx_q       <= idx_d;
            m1_q        <= m1_d;
            m2_q        <= m2_d;
            m3_q        <= m3_d;
            m4_q        <= m4_d;
            v_q         <= v_d;
            cap_q       <= cap_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            eng_en_q    <= eng_en_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign eng_en    = eng_en_q;
    assign eng_M1    = m1_q;
    assign eng_M2    = m2_q;
    assign eng_M3    = m3_q;
    assign eng_M4    = m4_q;
    assign eng_V     = v_q;

endmodule
